apb_master_n: RTL and testbench

Parametrised APB master that generalises the two-slave master to NUM_SLAVES one-hot selects with configurable data and address widths. It also adds an access timeout, an error flag and decode of out-of-range selects. It sits between the processor bus and N APB slaves, which typically front memory through their memory buses. It accepts one processor request at a time and runs the standard SETUP/ACCESS sequence, waiting on the selected slave's ready.

---
 rtl/apb_master_n_if.sv | 44 ++++
 rtl/apb_master_n.sv | 167 ++++++++++++++++
 tb/tb_apb_master_n.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_n_if.sv
// Bus bundle for apb_master_n: processor request/response side plus the
// fanned-out APB side. The master modport is the view of the APB master;
// the slave modport is the view of everything around it (processor and
// the N APB slaves).
interface apb_master_n_if #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8
);
    // Processor side
    logic                         start;
    logic                         write;
    logic [SEL_W-1:0]             sel;
    logic [ADDR_W-1:0]            addr;
    logic [DATA_W-1:0]            wdata;
    logic [7:0]                   wait_cycles;
    logic [DATA_W-1:0]            rdata;
    logic                         stable;
    logic                         error;
    logic                         busy;

    // APB side
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [7:0]                   pwait_cycles;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;

    modport master (
        input  start, write, sel, addr, wdata, wait_cycles, pready, prdata,
        output rdata, stable, error, busy,
        output psel, penable, pwrite, paddr, pwdata, pwait_cycles
    );

    modport slave (
        output start, write, sel, addr, wdata, wait_cycles, pready, prdata,
        input  rdata, stable, error, busy,
        input  psel, penable, pwrite, paddr, pwdata, pwait_cycles
    );
endinterface

// File: rtl/apb_master_n.sv
// APB master for NUM_SLAVES one-hot selected slaves. Takes one processor
// request at a time, runs SETUP/ACCESS on the selected slave, aborts an
// ACCESS phase that lasts TIMEOUT cycles, rejects out-of-range selects
// without touching the bus, and reports completion with a one-cycle
// stable pulse plus a sticky error status.
module apb_master_n #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    apb_master_n_if.master       bus
);
    // One extra bit so the counter can hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic                write_q,  write_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [7:0]          wait_q,   wait_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                error_q,  error_d;

    logic                sel_in_range;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic [NUM_SLAVES-1:0] psel_oh;

    // Out-of-range selects are possible whenever NUM_SLAVES < 2**SEL_W.
    assign sel_in_range = (int'(bus.sel) < NUM_SLAVES);

    // Pick out the addressed slave's ready and read data; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = bus.pready[i];
                sel_rdata = bus.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch of the case can infer a latch.
        state_d = state_q;
        write_d = write_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (sel_in_range) begin
                        write_d = bus.write;
                        sel_d   = bus.sel;
                        addr_d  = bus.addr;
                        wdata_d = bus.wdata;
                        wait_d  = bus.wait_cycles;
                        state_d = SETUP;
                    end else begin
                        // Bad select: complete immediately with error, bus untouched.
                        error_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end

            ACCESS: begin
                if (sel_ready) begin
                    if (!write_q) begin
                        rdata_d = sel_rdata;
                    end
                    error_d = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This was the TIMEOUT-th ACCESS cycle without ready.
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // One-hot select decode, active only while a slave is being addressed.
    always_comb begin
        psel_oh = '0;
        if (state_q == SETUP || state_q == ACCESS) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                psel_oh[i] = (sel_q == SEL_W'(i));
            end
        end
    end

    assign bus.psel         = psel_oh;
    assign bus.penable      = (state_q == ACCESS);
    assign bus.pwrite       = write_q;
    assign bus.paddr        = addr_q;
    assign bus.pwdata       = wdata_q;
    assign bus.pwait_cycles = wait_q;

    assign bus.rdata        = rdata_q;
    assign bus.error        = error_q;
    assign bus.stable       = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_n.sv
// Self-checking bench for apb_master_n: directed vector table, a few
// hand-written multi-cycle sequences, and random transfers checked
// against a transaction-level model of latency, error and read data.
module tb_apb_master_n;
    localparam int NS    = 3;
    localparam int SEL_W = 2;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int TOUT  = 16;
    localparam int BUDGET = TOUT + 10;
    localparam int NEVER  = 99;

    typedef struct {
        logic       wr;
        int         sel;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] waitc;
        int         k;          // ACCESS cycles with ready low before ready
        logic [7:0] rdval;      // read data of the selected slave
        logic [7:0] other;      // read data of every other slave
        int         exp_lat;    // start edge to stable cycle
        int         exp_acc;    // penable cycles
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_rdata;
    logic       m_err;

    apb_master_n_if #(.NUM_SLAVES(NS), .SEL_W(SEL_W), .DATA_W(DW), .ADDR_W(AW)) bus ();

    apb_master_n #(
        .NUM_SLAVES(NS), .SEL_W(SEL_W), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] all_outputs();
        return {bus.rdata, bus.stable, bus.error, bus.busy, bus.psel, bus.penable,
                bus.pwrite, bus.paddr, bus.pwdata, bus.pwait_cycles};
    endfunction

    // Transaction-level model: outcome follows from select range and ready delay alone.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        if (v.sel >= NS) begin
            r.exp_lat = 1;  r.exp_acc = 0;  r.exp_err = 1'b1;  r.exp_rdata = m_rdata;
        end else if (v.k < TOUT) begin
            r.exp_acc = v.k + 1;
            r.exp_lat = r.exp_acc + 2;
            r.exp_err = 1'b0;
            r.exp_rdata = v.wr ? m_rdata : v.rdval;
        end else begin
            r.exp_acc = TOUT;
            r.exp_lat = TOUT + 2;
            r.exp_err = 1'b1;
            r.exp_rdata = m_rdata;
        end
        return r;
    endfunction

    // Drive one request, act as the slaves, and measure the transfer.
    task automatic run_txn(input string tag, input vec_t v, input bit hold);
        int lat = 0;
        int acc = 0;
        int busy_n = 0;
        int psel_n = 0;
        int psel_bad = 0;
        int field_bad = 0;
        logic       act_err = 1'b0;
        logic [7:0] act_rd = '0;
        bit good = (v.sel < NS);
        logic [NS-1:0] oh = '0;
        if (good) oh[v.sel] = 1'b1;

        bus.start       = 1'b1;
        bus.write       = v.wr;
        bus.sel         = SEL_W'(v.sel);
        bus.addr        = v.addr;
        bus.wdata       = v.wdata;
        bus.wait_cycles = v.waitc;
        for (int i = 0; i < NS; i++)
            bus.prdata[i*DW +: DW] = (i == v.sel) ? v.rdval : v.other;
        bus.pready = ~oh;

        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (good && bus.psel == oh) psel_n++;
            else if (bus.psel != '0) psel_bad++;
            if (good && bus.busy &&
                {bus.pwrite, bus.paddr, bus.pwdata, bus.pwait_cycles} != {v.wr, v.addr, v.wdata, v.waitc})
                field_bad++;
            if (bus.penable) begin
                acc++;
                bus.pready = (acc - 1 >= v.k) ? '1 : ~oh;
            end else begin
                bus.pready = ~oh;
            end
            if (bus.stable) begin
                lat = cyc;
                act_err = bus.error;
                act_rd = bus.rdata;
                break;
            end
        end

        check({tag, " stable_seen"}, 64'(lat != 0), 64'(1));
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " penable_cycles"}, 64'(acc), 64'(v.exp_acc));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(v.exp_lat));
        check({tag, " psel_cycles"}, 64'(psel_n), good ? 64'(v.exp_acc + 1) : 64'(0));
        check({tag, " psel_bad"}, 64'(psel_bad), 64'(0));
        check({tag, " fields"}, 64'(field_bad), 64'(0));
        check({tag, " error"}, 64'(act_err), 64'(v.exp_err));
        check({tag, " rdata"}, 64'(act_rd), 64'(v.exp_rdata));

        @(negedge clk);
        check({tag, " post_idle"}, 64'({bus.stable, bus.busy, bus.psel, bus.penable}), 64'(0));
    endtask

    vec_t tbl [7];

    initial begin
        vec_t v;
        int n;

        tbl[0] = '{1'b1, 1, 8'h10, 8'h3C, 8'h00, 0,     8'h00, 8'hFF, 3,  1,  1'b0, 8'h00};
        tbl[1] = '{1'b0, 2, 8'h20, 8'h00, 8'h03, 3,     8'hA5, 8'hFF, 6,  4,  1'b0, 8'hA5};
        tbl[2] = '{1'b0, 0, 8'h30, 8'h00, 8'h00, NEVER, 8'h11, 8'hFF, 18, 16, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 0, 8'h31, 8'h00, 8'h00, 0,     8'h5A, 8'hFF, 3,  1,  1'b0, 8'h5A};
        tbl[4] = '{1'b0, 3, 8'h40, 8'h00, 8'h00, 0,     8'hEE, 8'hFF, 1,  0,  1'b1, 8'h5A};
        tbl[5] = '{1'b1, 2, 8'h50, 8'hC3, 8'h0F, 15,    8'h00, 8'hFF, 18, 16, 1'b0, 8'h5A};
        tbl[6] = '{1'b0, 1, 8'h60, 8'h00, 8'h00, 16,    8'h99, 8'hFF, 18, 16, 1'b1, 8'h5A};

        // Reset state
        reset = 1'b1;
        bus.start = 1'b0;  bus.write = 1'b0;  bus.sel = '0;  bus.addr = '0;
        bus.wdata = '0;    bus.wait_cycles = '0;  bus.pready = '0;  bus.prdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(all_outputs()), 64'(0));
        reset = 1'b0;
        m_rdata = 8'h00;
        m_err = 1'b0;

        // Directed vectors, issued back to back
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i], 1'b0);
            m_rdata = tbl[i].exp_rdata;
            m_err = tbl[i].exp_err;
        end

        // start held high through a 2-wait read: one transfer, restart only after DONE
        v = '{1'b0, 2, 8'h70, 8'h00, 8'h02, 2, 8'h77, 8'h00, 5, 3, 1'b0, 8'h77};
        run_txn("hold", v, 1'b1);
        @(negedge clk);
        check("restart_busy", 64'(bus.busy), 64'(1));
        check("restart_psel", 64'(bus.psel), 64'(3'b100));
        bus.start = 1'b0;
        bus.pready = '1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.stable) begin
                n = i;
                break;
            end
        end
        check("restart_latency", 64'(n), 64'(2));
        check("restart_rdata", 64'(bus.rdata), 64'(8'h77));
        check("restart_error", 64'(bus.error), 64'(0));
        @(negedge clk);
        m_rdata = 8'h77;
        m_err = 1'b0;

        // Reset during ACCESS of a read
        bus.start = 1'b1;  bus.write = 1'b0;  bus.sel = 2'd1;  bus.addr = 8'h80;
        bus.prdata = '0;
        bus.prdata[1*DW +: DW] = 8'h33;
        bus.pready = 3'b101;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_penable", 64'(bus.penable), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", 64'(all_outputs()), 64'(0));
        reset = 1'b0;
        m_rdata = 8'h00;
        m_err = 1'b0;
        v = '{1'b0, 1, 8'h81, 8'h00, 8'h01, 1, 8'h42, 8'h0F, 0, 0, 1'b0, 8'h00};
        v = predict(v);
        run_txn("after_reset", v, 1'b0);
        m_rdata = v.exp_rdata;
        m_err = v.exp_err;

        // Random transfers against the model
        for (int t = 0; t < 40; t++) begin
            int r;
            v.wr    = 1'($urandom_range(0, 1));
            v.sel   = int'($urandom_range(0, 3));
            v.addr  = 8'($urandom);
            v.wdata = 8'($urandom);
            v.waitc = 8'($urandom);
            v.rdval = 8'($urandom);
            v.other = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 6)       v.k = r;
            else if (r == 6) v.k = TOUT - 1;
            else if (r == 7) v.k = TOUT;
            else             v.k = NEVER;
            v = predict(v);
            run_txn($sformatf("rnd%0d", t), v, 1'b0);
            m_rdata = v.exp_rdata;
            m_err = v.exp_err;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
